// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM encoding,
// nibble width and the index-width helper.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(words)), never less than one bit so WORDS=1 still has an index
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_nibble_adder.sv
// Combinational 4-bit ripple-carry adder built from single-bit full adders;
// also exposes the carry into bit 3 for signed-overflow detection.
module nibble_adder
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             c3
);

  logic [NIB_W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[NIB_W];
  assign c3   = w_c[NIB_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that walks two WORDS-nibble operands LSB first through a
// single 4-bit adder, one nibble per clock, with valid/ready on both sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W*WORDS-1:0] a,
  input  logic [NIB_W*WORDS-1:0] b,
  input  logic                   c_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*WORDS-1:0] sum,
  output logic                   c_out,
  output logic                   ovf
);

  localparam int W     = NIB_W * WORDS;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a, r_b, r_sum;
  logic             r_carry, r_c_out, r_ovf;

  logic [IDX_W+1:0] w_lsb;
  logic [NIB_W-1:0] w_s;
  logic             w_cout, w_c3;

  assign w_lsb = {r_idx, 2'b00};

  nibble_adder u_nibble_adder (
    .a    (r_a[w_lsb +: NIB_W]),
    .b    (r_b[w_lsb +: NIB_W]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout),
    .c3   (w_c3)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)          w_next = RUN;
      RUN:     if (r_idx == IDX_LAST) w_next = DONE;
      DONE:    if (out_ready)         w_next = IDLE;
      default:                        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b;
          r_carry <= c_in;
          r_idx   <= '0;
        end
        RUN: begin
          r_sum[w_lsb +: NIB_W] <= w_s;
          r_carry               <= w_cout;
          if (r_idx == IDX_LAST) begin
            r_c_out <= w_cout;
            r_ovf   <= w_c3 ^ w_cout;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

endmodule
